// File: rtl/matrix_mult_seq.sv
// rtl/matrix_mult_seq.sv - sequential NxN matrix multiplier with one shared MAC
//
// Computes C = A x B (or C = C + A x B in accumulate mode) one multiply-
// accumulate per cycle, traversing result elements row-major with the dot
// product index k as the inner loop. The operands are captured on the start
// edge. The result stays in an output register until the next operation.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request a new operation (accepted only while idle)
//   acc_mode  sampled with start: 0 -> C = A x B, 1 -> C = C + A x B
//   a_flat    matrix A, element (r,c) at [(r*N+c)*DW +: DW]
//   b_flat    matrix B, same packing
//   c_flat    result register, element (r,c) at [(r*N+c)*CW +: CW]
//   busy      operation in progress
//   done      one-cycle completion pulse

module matrix_mult_seq #(
    parameter int N      = 2,
    parameter int DW     = 8,
    parameter int SIGNED = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       acc_mode,
    input  logic [N*N*DW-1:0]          a_flat,
    input  logic [N*N*DW-1:0]          b_flat,
    output logic [N*N*(2*DW+$clog2(N))-1:0] c_flat,
    output logic                       busy,
    output logic                       done
);

    localparam int CW = 2*DW + $clog2(N);
    localparam int IW = $clog2(N);
    localparam int EW = CW - 2*DW;
    localparam logic [IW-1:0] LAST = IW'(N-1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t          state_q;
    logic [DW-1:0]   a_q [N][N];
    logic [DW-1:0]   b_q [N][N];
    logic [CW-1:0]   c_q [N][N];
    logic            acc_mode_q;
    logic [IW-1:0]   i_q, j_q, k_q;
    logic [CW-1:0]   acc_q;
    logic            busy_q;
    logic            done_q;

    logic [DW-1:0]   a_el, b_el;
    logic [2*DW-1:0] prod;
    logic [CW-1:0]   prod_ext;
    logic [CW-1:0]   acc_d;
    logic [CW-1:0]   seed_d;
    logic [IW-1:0]   i_nxt, j_nxt;
    logic            j_wrap;
    logic            last_elem;

    always_comb begin
        a_el = a_q[i_q][k_q];
        b_el = b_q[k_q][j_q];

        // The low 2*DW bits of the product of sign-extended operands equal the
        // two's complement product, so one unsigned multiplier serves both modes.
        if (SIGNED != 0) begin
            prod = {{DW{a_el[DW-1]}}, a_el} * {{DW{b_el[DW-1]}}, b_el};
            prod_ext = {{EW{prod[2*DW-1]}}, prod};
        end else begin
            prod = {{DW{1'b0}}, a_el} * {{DW{1'b0}}, b_el};
            prod_ext = {{EW{1'b0}}, prod};
        end

        acc_d = acc_q + prod_ext;

        j_wrap    = (j_q == LAST);
        last_elem = j_wrap && (i_q == LAST) && (k_q == LAST);
        j_nxt     = j_wrap ? '0 : j_q + 1'b1;
        // Keep the next-row index in range even on the final element, so the
        // seed lookup below never addresses past the array for non-power-of-two N.
        if (j_wrap) begin
            i_nxt = (i_q == LAST) ? '0 : i_q + 1'b1;
        end else begin
            i_nxt = i_q;
        end

        // Each element is written exactly once per operation, so the old value
        // of the next element is still intact when it is used as the seed.
        seed_d = acc_mode_q ? c_q[i_nxt][j_nxt] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_mode_q <= 1'b0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                    c_q[r][c] <= '0;
                end
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int r = 0; r < N; r++) begin
                            for (int c = 0; c < N; c++) begin
                                a_q[r][c] <= a_flat[(r*N+c)*DW +: DW];
                                b_q[r][c] <= b_flat[(r*N+c)*DW +: DW];
                            end
                        end
                        acc_mode_q <= acc_mode;
                        i_q        <= '0;
                        j_q        <= '0;
                        k_q        <= '0;
                        acc_q      <= acc_mode ? c_q[0][0] : '0;
                        busy_q     <= 1'b1;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    if (k_q != LAST) begin
                        acc_q <= acc_d;
                        k_q   <= k_q + 1'b1;
                    end else begin
                        c_q[i_q][j_q] <= acc_d;
                        k_q           <= '0;
                        if (last_elem) begin
                            i_q     <= '0;
                            j_q     <= '0;
                            acc_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            i_q   <= i_nxt;
                            j_q   <= j_nxt;
                            acc_q <= seed_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign c_flat[(r*N+c)*CW +: CW] = c_q[r][c];
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule
